// File: rtl/if_prefetch.sv
// if_prefetch: in-order instruction prefetcher with credit-limited requests,
// redirect flush with stale-response discard, and a DEPTH-entry instruction FIFO.
module if_prefetch #(
    parameter int XLEN = 32,
    parameter int PC_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [XLEN-1:0]     imem_rdata_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                id_ready_i,
    output logic                if_valid_o,
    output logic [XLEN-1:0]     if_inst_o,
    output logic [PC_WIDTH-1:0] if_pc_o,
    output logic [PC_WIDTH-1:0] if_pcplus4_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]       outstanding, discard, count;
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [XLEN-1:0]     mem_inst [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc [DEPTH];
    logic                grant, push, drop, pop;

    // every in-flight request reserves a FIFO slot, so a push can never overflow
    assign imem_req_o   = ({1'b0, outstanding} + {1'b0, count} < DEPTH_C) && !redirect_i && !rst;
    assign imem_addr_o  = fetch_pc;
    assign grant        = imem_req_o && imem_gnt_i;
    assign push         = imem_rvalid_i && discard == '0 && !redirect_i;
    assign drop         = imem_rvalid_i && !push;
    assign if_valid_o   = count != '0;
    assign pop          = if_valid_o && id_ready_i && !redirect_i;
    assign if_inst_o    = mem_inst[rd_ptr];
    assign if_pc_o      = mem_pc[rd_ptr];
    assign if_pcplus4_o = if_pc_o + PC_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= RESET_PC;
            end
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
            // a response landing in the redirect cycle is already stale, so it is not counted
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
                resp_pc  <= redirect_pc_i;
                discard  <= outstanding - CW'(imem_rvalid_i);
                count    <= '0;
                wr_ptr   <= rd_ptr;
            end else begin
                if (grant) fetch_pc <= fetch_pc + PC_WIDTH'(4);
                if (push) begin
                    mem_inst[wr_ptr] <= imem_rdata_i;
                    mem_pc[wr_ptr]   <= resp_pc;
                    wr_ptr           <= wr_ptr + AW'(1);
                    resp_pc          <= resp_pc + PC_WIDTH'(4);
                end
                if (drop) discard <= discard - CW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed scenarios plus randomized traffic for if_prefetch,
// checked against an in-order fetch-stream model and a latency-based memory model.
module tb_if_prefetch;
    localparam int XLEN = 32;
    localparam int PW = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0;

    logic clk = 0, rst = 1;
    logic imem_req_o, if_valid_o;
    logic [PW-1:0] imem_addr_o, if_pc_o, if_pcplus4_o;
    logic [XLEN-1:0] if_inst_o;
    logic imem_gnt_i = 0, imem_rvalid_i = 0, redirect_i = 0, id_ready_i = 0;
    logic [XLEN-1:0] imem_rdata_i = '0;
    logic [PW-1:0] redirect_pc_i = '0;

    int checks = 0, errors = 0;
    int lat = 1;
    bit rv_rand = 0;
    int edge_n = 0;
    int delivered = 0;
    logic [31:0] exp_pc = RPC;
    logic hold_v = 0;
    logic [31:0] hold_pc, hold_inst;

    typedef struct packed { logic [31:0] addr; int due; } req_t;
    req_t pend[$];

    if_prefetch #(.XLEN(XLEN), .PC_WIDTH(PW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .id_ready_i(id_ready_i),
        .if_valid_o(if_valid_o), .if_inst_o(if_inst_o), .if_pc_o(if_pc_o), .if_pcplus4_o(if_pcplus4_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // memory: in-order responses, the front one no earlier than lat cycles after its grant
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            edge_n = 0;
            imem_rvalid_i <= 1'b0;
            imem_rdata_i <= '0;
        end else begin
            edge_n = edge_n + 1;
            if (imem_rvalid_i) void'(pend.pop_front());
            if (imem_req_o && imem_gnt_i) pend.push_back('{addr: imem_addr_o, due: edge_n + lat - 1});
            if (pend.size() > 0 && pend[0].due <= edge_n && (!rv_rand || $urandom_range(3) != 0)) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i <= memf(pend[0].addr);
            end else imem_rvalid_i <= 1'b0;
        end
    end

    // stream model: deliveries run contiguously from RESET_PC or the latest redirect target
    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_pc = RPC;
            hold_v = 0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!if_valid_o || if_pc_o !== hold_pc || if_inst_o !== hold_inst) begin
                    errors++;
                    $display("FAIL hold_stable got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", if_valid_o, if_pc_o, if_inst_o, hold_pc, hold_inst);
                end
            end
            checks++;
            if (pend.size() > DEPTH) begin
                errors++;
                $display("FAIL inflight_limit got=%0d want<=%0d", pend.size(), DEPTH);
            end
            hold_v = 0;
            if (redirect_i) exp_pc = redirect_pc_i;
            else if (if_valid_o && id_ready_i) begin
                checks++;
                if (if_pc_o !== exp_pc || if_inst_o !== memf(exp_pc) || if_pcplus4_o !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL delivery got pc=%h inst=%h pc4=%h want pc=%h inst=%h pc4=%h", if_pc_o, if_inst_o, if_pcplus4_o, exp_pc, memf(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else if (if_valid_o) begin
                hold_v = 1;
                hold_pc = if_pc_o;
                hold_inst = if_inst_o;
            end
        end
    end

    task automatic do_reset(input int l, input bit rr, input bit rdy);
        @(posedge clk);
        #1 rst = 1;
        redirect_i = 0;
        lat = l;
        rv_rand = rr;
        id_ready_i = rdy;
        imem_gnt_i = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        imem_gnt_i = 1;
        id_ready_i = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req_o, if_valid_o, if_inst_o, if_pc_o, if_pcplus4_o} !== {1'b0, 1'b0, 32'h0, RPC, RPC + 32'd4}) begin
            errors++;
            $display("FAIL reset_outputs got req=%b v=%b inst=%h pc=%h pc4=%h want 0 0 0 %h %h", imem_req_o, if_valid_o, if_inst_o, if_pc_o, if_pcplus4_o, RPC, RPC + 32'd4);
        end
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, RPC}) begin
            errors++;
            $display("FAIL reset_release got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, RPC);
        end
    endtask

    task automatic test_zero_wait;
        do_reset(1, 0, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (c < 2 ? (if_valid_o !== 1'b0) : ({if_valid_o, if_pc_o} !== {1'b1, 32'(4 * (c - 2))})) begin
                errors++;
                $display("FAIL zero_wait cycle=%0d got v=%b pc=%h want v=%0d pc=%h", c, if_valid_o, if_pc_o, c >= 2, 32'(4 * (c - 2)));
            end
        end
    endtask

    task automatic test_stall;
        int d0;
        do_reset(1, 0, 0);
        repeat (10) @(negedge clk);
        checks++;
        if (dut.count !== 3'd4 || dut.outstanding !== 3'd0 || imem_req_o !== 1'b0 || if_pc_o !== RPC || pend.size() != 0) begin
            errors++;
            $display("FAIL stall_full got count=%0d outst=%0d req=%b pc=%h mem_pending=%0d want 4 0 0 %h 0", dut.count, dut.outstanding, imem_req_o, if_pc_o, pend.size(), RPC);
        end
        @(posedge clk);
        #1 id_ready_i = 1;
        d0 = delivered;
        repeat (12) @(negedge clk);
        checks++;
        if (delivered - d0 != 11) begin
            errors++;
            $display("FAIL stall_resume got=%0d deliveries want=11", delivered - d0);
        end
    endtask

    task automatic test_redirect_latency;
        int n = 0, exp_d;
        do_reset(3, 0, 1);
        do begin @(negedge clk); n++; end while (pend.size() != 3 && n < 20);
        checks++;
        if (pend.size() != 3) begin
            errors++;
            $display("FAIL redir_lat_setup got pending=%0d want=3", pend.size());
        end
        exp_d = pend.size() - int'(imem_rvalid_i);
        redirect_pc_i = 32'h100;
        redirect_i = 1;
        @(posedge clk);
        #1 redirect_i = 0;
        @(negedge clk);
        checks++;
        if (dut.discard !== 3'(exp_d) || if_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_lat_discard got discard=%0d v=%b want discard=%0d v=0", dut.discard, if_valid_o, exp_d);
        end
        n = 0;
        while (!if_valid_o && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({if_valid_o, if_pc_o, if_pcplus4_o} !== {1'b1, 32'h100, 32'h104}) begin
            errors++;
            $display("FAIL redir_lat_first got v=%b pc=%h pc4=%h want v=1 pc=00000100 pc4=00000104", if_valid_o, if_pc_o, if_pcplus4_o);
        end
    endtask

    task automatic test_redirect_same_cycle;
        int n = 0, exp_d;
        do_reset(2, 0, 1);
        do begin @(negedge clk); n++; end while (!(imem_rvalid_i && if_valid_o && pend.size() >= 2) && n < 20);
        checks++;
        if (!(imem_rvalid_i && if_valid_o)) begin
            errors++;
            $display("FAIL same_cycle_setup got rvalid=%b v=%b want 1 1", imem_rvalid_i, if_valid_o);
        end
        exp_d = pend.size() - int'(imem_rvalid_i);
        redirect_pc_i = 32'h200;
        redirect_i = 1;
        @(posedge clk);
        #1 redirect_i = 0;
        @(negedge clk);
        checks++;
        if (dut.discard !== 3'(exp_d) || if_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_flush got discard=%0d v=%b want discard=%0d v=0", dut.discard, if_valid_o, exp_d);
        end
        n = 0;
        while (!if_valid_o && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({if_valid_o, if_pc_o} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL same_cycle_first got v=%b pc=%h want v=1 pc=00000200", if_valid_o, if_pc_o);
        end
    endtask

    task automatic test_wrap;
        int n = 0;
        do_reset(1, 0, 1);
        repeat (4) @(negedge clk);
        redirect_pc_i = 32'hFFFF_FFFC;
        redirect_i = 1;
        @(posedge clk);
        #1 redirect_i = 0;
        @(negedge clk);
        while (!if_valid_o && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({if_valid_o, if_pc_o, if_pcplus4_o} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            errors++;
            $display("FAIL wrap_first got v=%b pc=%h pc4=%h want v=1 pc=fffffffc pc4=00000000", if_valid_o, if_pc_o, if_pcplus4_o);
        end
        @(negedge clk);
        checks++;
        if ({if_valid_o, if_pc_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_second got v=%b pc=%h want v=1 pc=00000000", if_valid_o, if_pc_o);
        end
    endtask

    task automatic test_double_redirect;
        int n = 0, exp_d;
        do_reset(3, 0, 1);
        do begin @(negedge clk); n++; end while (pend.size() != 3 && n < 20);
        exp_d = pend.size() - int'(imem_rvalid_i);
        redirect_pc_i = 32'h400;
        redirect_i = 1;
        @(negedge clk);
        checks++;
        if (dut.discard !== 3'(exp_d)) begin
            errors++;
            $display("FAIL double_redir_first got discard=%0d want=%0d", dut.discard, exp_d);
        end
        exp_d = pend.size() - int'(imem_rvalid_i);
        redirect_pc_i = 32'h800;
        @(posedge clk);
        #1 redirect_i = 0;
        @(negedge clk);
        checks++;
        if (dut.discard !== 3'(exp_d) || dut.outstanding !== 3'(pend.size())) begin
            errors++;
            $display("FAIL double_redir_second got discard=%0d outst=%0d want discard=%0d outst=%0d", dut.discard, dut.outstanding, exp_d, pend.size());
        end
        n = 0;
        while (!if_valid_o && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({if_valid_o, if_pc_o} !== {1'b1, 32'h800}) begin
            errors++;
            $display("FAIL double_redir_target got v=%b pc=%h want v=1 pc=00000800", if_valid_o, if_pc_o);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(2, 1, 1);
        repeat (20) begin
            @(posedge clk);
            #1 id_ready_i = ($urandom_range(2) != 0);
        end
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        checks++;
        if ({imem_req_o, if_valid_o, if_inst_o, if_pc_o, if_pcplus4_o} !== {1'b0, 1'b0, 32'h0, RPC, RPC + 32'd4}) begin
            errors++;
            $display("FAIL midreset_outputs got req=%b v=%b inst=%h pc=%h pc4=%h want 0 0 0 %h %h", imem_req_o, if_valid_o, if_inst_o, if_pc_o, if_pcplus4_o, RPC, RPC + 32'd4);
        end
        @(posedge clk);
        #1 rst = 0;
        id_ready_i = 1;
        @(negedge clk);
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, RPC}) begin
            errors++;
            $display("FAIL midreset_restart got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, RPC);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random;
        int d0;
        logic [31:0] t;
        do_reset(1, 1, 1);
        d0 = delivered;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c % 200 == 0) lat = $urandom_range(3, 1);
            imem_gnt_i = ($urandom_range(3) != 0);
            id_ready_i = ($urandom_range(2) != 0);
            t = $urandom;
            t[1:0] = 2'b00;
            redirect_pc_i = t;
            redirect_i = ($urandom_range(19) == 0);
        end
        @(posedge clk);
        #1 redirect_i = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (delivered - d0 < 300) begin
            errors++;
            $display("FAIL random_progress got=%0d deliveries want>=300", delivered - d0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_latency();
        test_redirect_same_cycle();
        test_wrap();
        test_double_redirect();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, instruction width.
- PC_WIDTH, default 32, PC width.
- DEPTH, default 4, instruction buffer depth and in-flight limit; power of 2, at least 2.
- RESET_PC, default 0, first fetch address.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  PC_WIDTH  fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; in order, one per grant, at least 1 cycle after grant.
- imem_rdata_i  in  XLEN  response instruction.
- redirect_i  in  1  taken branch/jump; overrides sequential fetch.
- redirect_pc_i  in  PC_WIDTH  redirect target.
- id_ready_i  in  1  decode accepts head instruction.
- if_valid_o  out  1  buffer head valid.
- if_inst_o  out  XLEN  head instruction.
- if_pc_o  out  PC_WIDTH  head PC.
- if_pcplus4_o  out  PC_WIDTH  if_pc_o + 4, modulo 2^PC_WIDTH.

Function
REQ-003 State SHALL be:
- fetch_pc: next address to request.
- resp_pc: PC of the next accepted response.
- outstanding: granted requests not yet answered, 0..DEPTH.
- discard: stale responses still to drop, never more than outstanding.
- FIFO: DEPTH entries of {inst, pc}, with count 0..DEPTH.
REQ-004 imem_req_o SHALL equal (outstanding + count < DEPTH) AND NOT redirect_i AND NOT rst; imem_addr_o SHALL equal fetch_pc.
REQ-005 A grant (imem_req_o AND imem_gnt_i) SHALL set fetch_pc to fetch_pc + 4 and increment outstanding; a held request SHALL keep its address until granted.
REQ-006 A response while discard = 0 SHALL push {imem_rdata_i, resp_pc} into the FIFO, set resp_pc to resp_pc + 4, and decrement outstanding.
REQ-007 A response while discard > 0 SHALL be dropped, decrementing both discard and outstanding.
REQ-008 Pop SHALL occur on if_valid_o AND id_ready_i and remove the head entry at the clock edge.
REQ-009 A simultaneous push and pop SHALL leave count unchanged.
REQ-010 REQ-004 SHALL guarantee that a push never occurs when the FIFO is full; a pop frees a credit on the following cycle only.
REQ-011 if_valid_o SHALL equal (count != 0); if_inst_o and if_pc_o SHALL come from the head register and be stable while id_ready_i is low.
REQ-012 Redirect SHALL take priority over sequential fetch. On redirect_i at an edge:
- flush the FIFO (count = 0);
- fetch_pc and resp_pc = redirect_pc_i;
- discard = outstanding - (1 if imem_rvalid_i that cycle, else 0);
- a pop requested in the same cycle is void.
REQ-013 After a redirect, the first instruction delivered SHALL be at redirect_pc_i; every in-flight stale response SHALL be dropped.
REQ-014 A redirect during a nonzero discard SHALL recompute discard per REQ-012 and SHALL not lose count of outstanding responses.
REQ-015 All PC arithmetic SHALL wrap modulo 2^PC_WIDTH.
REQ-016 Latency with zero-wait memory (gnt in the request cycle, rvalid one cycle later) SHALL be: if_valid_o asserts 2 cycles after the request; sustained throughput is 1 instruction per cycle.

Reset
REQ-017 While rst is high, the block SHALL hold:
- fetch_pc = resp_pc = RESET_PC;
- outstanding = discard = count = 0;
- imem_req_o = 0, if_valid_o = 0.
- if_inst_o = 0, if_pc_o = RESET_PC, if_pcplus4_o = RESET_PC + 4.
REQ-018 Asserting rst mid-operation SHALL abandon in-flight requests without tracking them. The memory side SHALL be reset with the block, so no stale response arrives after reset.
REQ-019 On the first cycle after rst deasserts, the block SHALL drive imem_req_o = 1 with imem_addr_o = RESET_PC.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Zero-wait memory, id_ready_i = 1 -> if_pc_o sequence 0x0, 0x4, 0x8, ... one per cycle from cycle 2.
- id_ready_i = 0 for 10 cycles -> count = 4, outstanding = 0, imem_req_o = 0, head stays 0x0; id_ready_i back to 1 -> in-order delivery with no gaps or duplicates.
- 3-cycle memory latency with 3 requests outstanding, redirect_pc_i = 0x100 -> 3 responses dropped, first if_pc_o = 0x100, if_pcplus4_o = 0x104.
- Redirect in the same cycle as a response and a pop -> FIFO empty next cycle, discard = outstanding - 1, next delivered PC = target.
- Redirect to 0xFFFF_FFFC with PC_WIDTH = 32 -> delivered PCs 0xFFFF_FFFC, 0x0; if_pcplus4_o = 0x0 at the first.
- rst pulse mid-stream -> all outputs at reset values; after release, fetch restarts at RESET_PC.
